// File: rtl/floor_call_register.sv
// floor_call_register: synchronises and debounces raw floor-call buttons,
// latches them as pending calls and presents one registered SCAN-ordered
// target floor to the elevator FSM.
//   Latency: button press to pending is 2 (sync) + DEBOUNCE_CYCLES + 1 edges;
//            target_floor/call_valid follow pending by one more edge.
//   Backpressure: none; calls are held in pending until arrive clears them.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   btn                 - raw asynchronous call buttons (bit i = floor i)
//   cur_floor, dir_up   - car position and travel direction from the FSM
//   arrive              - one-cycle pulse, clears the call at cur_floor
//   pending             - latched outstanding calls
//   call_pulse          - one-cycle pulse when any new call is latched
//   call_valid          - target_floor is meaningful (some call pending)
//   target_floor        - registered next floor to serve
module floor_call_register #(
    parameter int N_FLOORS        = 4,
    parameter int FLOOR_W         = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]  cur_floor,
    input  logic                dir_up,
    input  logic                arrive,
    output logic [N_FLOORS-1:0] pending,
    output logic                call_pulse,
    output logic                call_valid,
    output logic [FLOOR_W-1:0]  target_floor
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_FLOORS-1:0] sync1;
    logic [N_FLOORS-1:0] sync2;
    logic [N_FLOORS-1:0] stable;
    logic [N_FLOORS-1:0] stable_d;
    logic [CNT_W-1:0]    cnt [N_FLOORS];

    logic [N_FLOORS-1:0] rise;
    logic [N_FLOORS-1:0] clr;
    logic [N_FLOORS-1:0] pending_nxt;

    logic                found_ge;
    logic                found_le;
    logic                found_gt;
    logic [FLOOR_W-1:0]  lo_ge;
    logic [FLOOR_W-1:0]  hi_lt;
    logic [FLOOR_W-1:0]  hi_le;
    logic [FLOOR_W-1:0]  lo_gt;
    logic [FLOOR_W-1:0]  tgt_nxt;

    // Only a debounced 0->1 transition is a new call; releases are ignored.
    assign rise = stable & ~stable_d;

    // A floor index outside the building never matches, so arrive is a no-op then.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            clr[i] = arrive && (cur_floor == FLOOR_W'(i));
        end
    end

    // Clear has priority: a call raised at the floor the car is stopped at
    // is already being served.
    assign pending_nxt = (pending | rise) & ~clr;

    // SCAN candidates. Ascending scan: "first found" gives the lowest,
    // "last written" gives the highest.
    always_comb begin
        found_ge = 1'b0;
        found_le = 1'b0;
        found_gt = 1'b0;
        lo_ge    = '0;
        hi_lt    = '0;
        hi_le    = '0;
        lo_gt    = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i]) begin
                if (FLOOR_W'(i) >= cur_floor && !found_ge) begin
                    lo_ge    = FLOOR_W'(i);
                    found_ge = 1'b1;
                end
                if (FLOOR_W'(i) < cur_floor) begin
                    hi_lt = FLOOR_W'(i);
                end
                if (FLOOR_W'(i) <= cur_floor) begin
                    hi_le    = FLOOR_W'(i);
                    found_le = 1'b1;
                end
                if (FLOOR_W'(i) > cur_floor && !found_gt) begin
                    lo_gt    = FLOOR_W'(i);
                    found_gt = 1'b1;
                end
            end
        end
    end

    // Fallback candidates default to 0, which is also the idle target.
    always_comb begin
        tgt_nxt = '0;
        if (dir_up) begin
            tgt_nxt = found_ge ? lo_ge : hi_lt;
        end else begin
            tgt_nxt = found_le ? hi_le : lo_gt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1        <= '0;
            sync2        <= '0;
            stable       <= '0;
            stable_d     <= '0;
            pending      <= '0;
            call_pulse   <= 1'b0;
            call_valid   <= 1'b0;
            target_floor <= '0;
            for (int i = 0; i < N_FLOORS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            // Accept a level change only after DEBOUNCE_CYCLES consecutive
            // mismatching samples; any matching sample restarts the count.
            for (int i = 0; i < N_FLOORS; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            pending      <= pending_nxt;
            call_pulse   <= |(pending_nxt & ~pending);
            // Target is derived from the registered pending, so it lags by one edge.
            call_valid   <= |pending;
            target_floor <= tgt_nxt;
        end
    end

endmodule

// File: tb/tb_floor_call_register.sv
module tb_floor_call_register;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic [1:0] cur_floor;
    logic       dir_up;
    logic       arrive;
    logic [3:0] pending;
    logic       call_pulse;
    logic       call_valid;
    logic [1:0] target_floor;

    floor_call_register #(
        .N_FLOORS(4),
        .FLOOR_W(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .cur_floor(cur_floor),
        .dir_up(dir_up),
        .arrive(arrive),
        .pending(pending),
        .call_pulse(call_pulse),
        .call_valid(call_valid),
        .target_floor(target_floor)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; an expectation tagged with edge e
    // is compared on the falling edge that follows rising edge e.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         e;
        logic [3:0] pend;
        logic       pulse;
        logic       valid;
        logic [1:0] tgt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic expect_at(input string name, input int e, input logic [3:0] pend,
                             input logic pulse, input logic valid, input logic [1:0] tgt);
        exp_t x;
        x.name  = name;
        x.e     = e;
        x.pend  = pend;
        x.pulse = pulse;
        x.valid = valid;
        x.tgt   = tgt;
        q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops every expectation due at this edge and compares.
    exp_t m;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].e <= cyc) begin
            m = q.pop_front();
            n_tests++;
            if (m.e < cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for edge %0d missed (now edge %0d)", m.name, m.e, cyc);
            end else if (pending !== m.pend || call_pulse !== m.pulse ||
                         call_valid !== m.valid || target_floor !== m.tgt) begin
                n_fail++;
                $display("FAIL %s @edge %0d: got pend=%b pulse=%b valid=%b tgt=%0d, want pend=%b pulse=%b valid=%b tgt=%0d",
                         m.name, cyc, pending, call_pulse, call_valid, target_floor,
                         m.pend, m.pulse, m.valid, m.tgt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst       = 1'b1;
        btn       = 4'b0000;
        cur_floor = 2'd0;
        dir_up    = 1'b1;
        arrive    = 1'b0;
        step(2);

        // Reset state
        expect_at("reset_state", cyc, 4'b0000, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;

        // Latency: floor 2 press first sampled at edge c+1
        c   = cyc;
        btn = 4'b0100;
        expect_at("lat_before", c + 6, 4'b0000, 1'b0, 1'b0, 2'd0);
        expect_at("lat_pend",   c + 7, 4'b0100, 1'b1, 1'b0, 2'd0);
        expect_at("lat_target", c + 8, 4'b0100, 1'b0, 1'b1, 2'd2);
        step(8);
        btn = 4'b0000;
        expect_at("release_ignored", c + 16, 4'b0100, 1'b0, 1'b1, 2'd2);
        step(8);

        // Arrive clear on floor 2
        c         = cyc;
        cur_floor = 2'd2;
        arrive    = 1'b1;
        expect_at("arrive_clr",     c + 1, 4'b0000, 1'b0, 1'b1, 2'd2);
        expect_at("arrive_clr_tgt", c + 2, 4'b0000, 1'b0, 1'b0, 2'd0);
        step(1);
        arrive = 1'b0;
        step(1);

        // Bounce rejection on floor 1: toggles every 2 cycles for 20 cycles
        for (int k = 0; k < 10; k++) begin
            btn = k[0] ? 4'b0000 : 4'b0010;
            for (int j = 0; j < 2; j++) begin
                expect_at("bounce", cyc + 1, 4'b0000, 1'b0, 1'b0, 2'd0);
                step(1);
            end
        end
        btn = 4'b0000;
        for (int j = 0; j < 8; j++) begin
            expect_at("bounce_tail", cyc + 1, 4'b0000, 1'b0, 1'b0, 2'd0);
            step(1);
        end

        // SCAN ordering with pending = 1011
        c         = cyc;
        btn       = 4'b1011;
        cur_floor = 2'd1;
        dir_up    = 1'b1;
        expect_at("scan_latch",    c + 7, 4'b1011, 1'b1, 1'b0, 2'd0);
        expect_at("scan_f1_up",    c + 8, 4'b1011, 1'b0, 1'b1, 2'd1);
        step(8);
        btn       = 4'b0000;
        cur_floor = 2'd2;
        dir_up    = 1'b1;
        expect_at("scan_f2_up",    c + 9, 4'b1011, 1'b0, 1'b1, 2'd3);
        step(1);
        dir_up    = 1'b0;
        expect_at("scan_f2_dn",    c + 10, 4'b1011, 1'b0, 1'b1, 2'd1);
        step(1);
        cur_floor = 2'd0;
        expect_at("scan_f0_dn",    c + 11, 4'b1011, 1'b0, 1'b1, 2'd0);
        step(1);
        cur_floor = 2'd1;
        dir_up    = 1'b1;
        arrive    = 1'b1;
        expect_at("scan_clr1",     c + 12, 4'b1001, 1'b0, 1'b1, 2'd1);
        step(1);
        cur_floor = 2'd3;
        expect_at("scan_clr3",     c + 13, 4'b0001, 1'b0, 1'b1, 2'd3);
        step(1);
        arrive    = 1'b0;
        cur_floor = 2'd2;
        expect_at("scan_wrap_up",  c + 14, 4'b0001, 1'b0, 1'b1, 2'd0);
        step(4);

        // Floor-1 rise on the same edge as arrive at floor 1: clear wins
        c   = cyc;
        btn = 4'b0010;
        step(6);
        cur_floor = 2'd1;
        arrive    = 1'b1;
        expect_at("sim_same_floor",   c + 7, 4'b0001, 1'b0, 1'b1, 2'd0);
        expect_at("sim_same_floor_2", c + 8, 4'b0001, 1'b0, 1'b1, 2'd0);
        step(1);
        arrive = 1'b0;
        btn    = 4'b0000;
        step(10);

        // Latch floor 3, then floor-1 rise with arrive at floor 3
        c         = cyc;
        btn       = 4'b1000;
        cur_floor = 2'd3;
        expect_at("f3_latch", c + 7, 4'b1001, 1'b1, 1'b1, 2'd0);
        step(7);
        btn = 4'b0000;
        step(10);
        c   = cyc;
        btn = 4'b0010;
        step(6);
        arrive = 1'b1;
        expect_at("sim_other_floor",   c + 7, 4'b0011, 1'b1, 1'b1, 2'd3);
        expect_at("sim_other_floor_2", c + 8, 4'b0011, 1'b0, 1'b1, 2'd1);
        step(1);
        arrive = 1'b0;
        btn    = 4'b0000;
        step(10);

        // Reset with floor 0 mid-debounce, button held through reset
        c   = cyc;
        btn = 4'b0001;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_at("rst_mid_clear", c + 5, 4'b0000, 1'b0, 1'b0, 2'd0);
        expect_at("rst_redeb_pre", c + 11, 4'b0000, 1'b0, 1'b0, 2'd0);
        expect_at("rst_redeb",     c + 12, 4'b0001, 1'b1, 1'b0, 2'd0);
        expect_at("rst_redeb_tgt", c + 13, 4'b0001, 1'b0, 1'b1, 2'd0);
        step(9);

        for (int j = 0; j < 30 && q.size() > 0; j++) step(1);
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations never compared", q.size());
            n_fail += q.size();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
